// File: rtl/bht_update_ctrl.sv
// Branch history table update sequencer: buffers resolved-branch reports,
// performs one read-modify-write per cycle on the table update port, raises a
// one-cycle redirect on mispredict and walks the table to clear it.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_CLEAR | writing zeros to entry clr_idx, one entry per cycle
// S_RUN   | popping one buffered report per cycle into the table
module bht_update_ctrl #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 24,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [31:0]       res_pc,
  input  logic [31:0]       res_target,
  input  logic              res_taken,
  input  logic [31:0]       res_pred_pc,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic              tbl_rd_avail,
  input  logic [TAG_W-1:0]  tbl_rd_tag,
  input  logic [1:0]        tbl_rd_cnt,
  input  logic [29:0]       tbl_rd_target,
  output logic              tbl_we,
  output logic              tbl_wr_avail,
  output logic [TAG_W-1:0]  tbl_wr_tag,
  output logic [1:0]        tbl_wr_cnt,
  output logic [29:0]       tbl_wr_target,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] NO_JUMP        = 2'b00;
  localparam logic [1:0] WEAKLY_NO_JUMP = 2'b01;
  localparam logic [1:0] WEAKLY_JUMP    = 2'b11;
  localparam logic [1:0] JUMP           = 2'b10;

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;

  // FIFO payload: pc[31:2], target[31:2], direction
  logic [29:0]        fifo_pc_q  [DEPTH];
  logic [29:0]        fifo_tgt_q [DEPTH];
  logic               fifo_tk_q  [DEPTH];

  logic               fifo_full, fifo_empty, push, pop;
  logic [29:0]        head_pc, head_tgt;
  logic               head_tk;
  logic [IDX_W-1:0]   head_idx;
  logic [TAG_W-1:0]   head_tag;
  logic               hit;
  logic [1:0]         rmw_cnt;
  logic [29:0]        rmw_tgt;
  logic [31:0]        correct_pc;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign res_ready  = !fifo_full && !flush_req;
  assign push       = res_valid && res_ready;

  assign head_pc  = fifo_pc_q[rd_ptr_q];
  assign head_tgt = fifo_tgt_q[rd_ptr_q];
  assign head_tk  = fifo_tk_q[rd_ptr_q];
  assign head_idx = head_pc[29:30-IDX_W];
  assign head_tag = head_pc[TAG_W-1:0];
  assign hit      = tbl_rd_avail && (tbl_rd_tag == head_tag);

  assign busy           = (state_q == S_CLEAR);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  // Saturating counter step and target selection for the head report
  always_comb begin
    rmw_cnt = WEAKLY_NO_JUMP;
    rmw_tgt = tbl_rd_target;
    if (hit) begin
      unique case (tbl_rd_cnt)
        NO_JUMP:        rmw_cnt = head_tk ? WEAKLY_NO_JUMP : NO_JUMP;
        WEAKLY_NO_JUMP: rmw_cnt = head_tk ? WEAKLY_JUMP    : NO_JUMP;
        WEAKLY_JUMP:    rmw_cnt = head_tk ? JUMP           : WEAKLY_NO_JUMP;
        default:        rmw_cnt = head_tk ? JUMP           : WEAKLY_JUMP;
      endcase
      rmw_tgt = head_tk ? head_tgt : tbl_rd_target;
    end else begin
      rmw_cnt = head_tk ? WEAKLY_JUMP : WEAKLY_NO_JUMP;
      rmw_tgt = head_tk ? head_tgt : (head_pc + 30'd1);
    end
  end

  // Next-state, table port drive and pop decision
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    pop           = 1'b0;
    tbl_idx       = head_idx;
    tbl_we        = 1'b0;
    tbl_wr_avail  = 1'b0;
    tbl_wr_tag    = '0;
    tbl_wr_cnt    = 2'b00;
    tbl_wr_target = '0;
    unique case (state_q)
      S_CLEAR: begin
        tbl_idx   = clr_idx_q;
        tbl_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = S_RUN;
      end
      default: begin
        // a flush drops the head too, so nothing stale reaches the table
        if (!fifo_empty && !flush_req) begin
          pop           = 1'b1;
          tbl_we        = 1'b1;
          tbl_wr_avail  = 1'b1;
          tbl_wr_tag    = head_tag;
          tbl_wr_cnt    = rmw_cnt;
          tbl_wr_target = rmw_tgt;
        end
      end
    endcase
    if (flush_req) begin
      state_d   = S_CLEAR;
      clr_idx_d = '0;
    end
  end

  // Mispredict is judged on the report as it is accepted
  always_comb begin
    correct_pc       = res_taken ? res_target : (res_pc + 32'd4);
    redirect_valid_d = push && (correct_pc != res_pred_pc);
    redirect_pc_d    = redirect_valid_d ? correct_pc : redirect_pc_q;
  end

  // Control state, FIFO pointers and redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_CLEAR;
      clr_idx_q        <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      clr_idx_q        <= clr_idx_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      if (flush_req) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

  // FIFO payload storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= res_pc[31:2];
      fifo_tgt_q[wr_ptr_q] <= res_target[31:2];
      fifo_tk_q[wr_ptr_q]  <= res_taken;
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Bench for bht_update_ctrl: table model, directed reports, and a scoreboard
// monitor that checks table writes and redirects as the design presents them.
module tb_bht_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc, res_target, res_pred_pc;
  logic        res_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [5:0]  tbl_idx;
  logic        tbl_rd_avail;
  logic [23:0] tbl_rd_tag;
  logic [1:0]  tbl_rd_cnt;
  logic [29:0] tbl_rd_target;
  logic        tbl_we;
  logic        tbl_wr_avail;
  logic [23:0] tbl_wr_tag;
  logic [1:0]  tbl_wr_cnt;
  logic [29:0] tbl_wr_target;
  logic        busy;

  typedef struct packed {
    logic [5:0]  idx;
    logic        av;
    logic [23:0] tag;
    logic [1:0]  cnt;
    logic [29:0] tgt;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int          n_chk = 0;
  int          n_fail = 0;

  logic        t_av  [64];
  logic [23:0] t_tag [64];
  logic [1:0]  t_cnt [64];
  logic [29:0] t_tgt [64];

  always #5 clk = ~clk;

  bht_update_ctrl #(.IDX_W(6), .TAG_W(24), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_target(res_target), .res_taken(res_taken), .res_pred_pc(res_pred_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .tbl_idx(tbl_idx), .tbl_rd_avail(tbl_rd_avail), .tbl_rd_tag(tbl_rd_tag),
    .tbl_rd_cnt(tbl_rd_cnt), .tbl_rd_target(tbl_rd_target), .tbl_we(tbl_we),
    .tbl_wr_avail(tbl_wr_avail), .tbl_wr_tag(tbl_wr_tag),
    .tbl_wr_cnt(tbl_wr_cnt), .tbl_wr_target(tbl_wr_target), .busy(busy)
  );

  // table model: combinational read, edge-committed write
  assign tbl_rd_avail  = t_av[tbl_idx];
  assign tbl_rd_tag    = t_tag[tbl_idx];
  assign tbl_rd_cnt    = t_cnt[tbl_idx];
  assign tbl_rd_target = t_tgt[tbl_idx];

  always @(posedge clk) begin
    if (tbl_we) begin
      t_av[tbl_idx]  <= tbl_wr_avail;
      t_tag[tbl_idx] <= tbl_wr_tag;
      t_cnt[tbl_idx] <= tbl_wr_cnt;
      t_tgt[tbl_idx] <= tbl_wr_target;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (tbl_we && !busy) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", {1'b1, tbl_idx}, 64'd0);
        end else begin
          check("table_write", {tbl_idx, tbl_wr_avail, tbl_wr_tag, tbl_wr_cnt, tbl_wr_target},
                exp_wr.pop_front());
        end
      end
      if (redirect_valid) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_redirect", {1'b1, redirect_pc}, 64'd0);
        end else begin
          check("redirect_pc", redirect_pc, exp_rd.pop_front());
        end
      end
    end
  end

  // caller is just after a rising edge; returns just after the accept edge
  task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic [31:0] pred, input logic rd_exp, input logic [31:0] rd_pc,
                      input logic wr_exp, input wr_t w);
    int k;
    res_valid = 1'b1; res_pc = pc; res_target = tgt; res_taken = tk; res_pred_pc = pred;
    k = 0;
    @(negedge clk);
    while (!res_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!res_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (rd_exp) exp_rd.push_back(rd_pc);
      if (wr_exp) exp_wr.push_back(w);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    @(negedge clk);
    check("ready_in_flush", res_ready, 1'b0);
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("clear_done", busy, 1'b0);
  endtask

  initial begin
    int n;
    logic [31:0] pc, tgt;
    rst = 1'b1; flush_req = 1'b0; res_valid = 1'b0;
    res_pc = '0; res_target = '0; res_taken = 1'b0; res_pred_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state and the 64-entry clear walk
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_ready", res_ready, 1'b1);
      end
      check("clr_walk", {busy, tbl_we, tbl_idx, tbl_wr_avail, tbl_wr_tag, tbl_wr_cnt, tbl_wr_target},
            {1'b1, 1'b1, 6'(i), 1'b0, 24'd0, 2'd0, 30'd0});
    end
    @(negedge clk);
    check("run_idle", {busy, tbl_we}, 2'b00);
    @(posedge clk); #1;

    // miss allocate, taken, mispredicted
    send(32'h0000_1008, 32'h0000_2000, 1'b1, 32'h0000_100C, 1'b1, 32'h0000_2000,
         1'b1, '{6'd0, 1'b1, 24'h000402, 2'b11, 30'h800});

    // saturation then decay on idx 1, tag 0xC04
    send(32'h0400_3010, 32'h0400_5000, 1'b1, 32'h0400_3014, 1'b1, 32'h0400_5000,
         1'b1, '{6'd1, 1'b1, 24'h000C04, 2'b11, 30'h0100_1400});
    send(32'h0400_3010, 32'h0400_5000, 1'b1, 32'h0400_5000, 1'b0, 32'h0,
         1'b1, '{6'd1, 1'b1, 24'h000C04, 2'b10, 30'h0100_1400});
    send(32'h0400_3010, 32'h0400_5000, 1'b1, 32'h0400_5000, 1'b0, 32'h0,
         1'b1, '{6'd1, 1'b1, 24'h000C04, 2'b10, 30'h0100_1400});
    send(32'h0400_3010, 32'h0400_5000, 1'b0, 32'h0400_5000, 1'b1, 32'h0400_3014,
         1'b1, '{6'd1, 1'b1, 24'h000C04, 2'b11, 30'h0100_1400});
    send(32'h0400_3010, 32'h0400_5000, 1'b0, 32'h0400_3014, 1'b0, 32'h0,
         1'b1, '{6'd1, 1'b1, 24'h000C04, 2'b01, 30'h0100_1400});

    // correctly predicted not-taken miss: no redirect
    send(32'h0800_0040, 32'h0000_0000, 1'b0, 32'h0800_0044, 1'b0, 32'h0,
         1'b1, '{6'd2, 1'b1, 24'h000010, 2'b01, 30'h0200_0011});
    repeat (4) @(posedge clk);
    #1;

    // flush from RUN, then fill the FIFO during the clear
    do_flush();
    for (int k = 3; k <= 6; k++) begin
      pc  = (32'(k) << 26) | 32'h0000_0400;
      tgt = 32'h0000_8000 + 32'(k) * 32'h10;
      send(pc, tgt, 1'b1, pc + 32'd4, 1'b1, tgt,
           1'b1, '{6'(k), 1'b1, 24'h000100, 2'b11, tgt[31:2]});
    end
    res_valid = 1'b1; res_pc = 32'h1C00_0400; res_target = 32'h0000_8070;
    res_taken = 1'b1; res_pred_pc = 32'h1C00_0404;
    @(negedge clk);
    check("ready_when_full", res_ready, 1'b0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    wait_idle();
    repeat (8) @(posedge clk);
    #1;

    // flush while three entries are buffered
    do_flush();
    for (int k = 8; k <= 10; k++) begin
      pc  = (32'(k) << 26) | 32'h0000_0800;
      tgt = 32'h0001_0000 + 32'(k) * 32'h20;
      send(pc, tgt, 1'b1, tgt, 1'b0, 32'h0, 1'b0, '0);
    end
    do_flush();
    n = 0;
    @(negedge clk);
    check("flush_restart_idx", tbl_idx, 6'd0);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("flush_clear_len", 32'(n), 32'd64);
    repeat (10) @(negedge clk);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
